alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter_alu.sv | 32 +++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, datapath width and the arbiter stage record.
package alu_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_SLL = 4'd5;
  localparam logic [3:0] ALU_OP_SRL = 4'd6;
  localparam logic [3:0] ALU_OP_SRA = 4'd7;

  // One accepted request as held in the stage register. The tag width is a
  // per-instance parameter, so the tag is kept in its own register beside it.
  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic            id;
  } stage_t;

  // Codes 8-15 have no defined operation.
  function automatic logic op_undefined(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester request bus plus single result channel.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_op1_0, req_op1_1;
  logic [XLEN-1:0] req_op2_0, req_op2_1;
  logic [3:0]      req_alu_op_0, req_alu_op_1;
  logic [TAG_W-1:0] req_tag_0, req_tag_1;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic            rsp_err;

  // Requesters plus result consumer.
  modport master (
    output req_valid, req_op1_0, req_op1_1, req_op2_0, req_op2_1,
           req_alu_op_0, req_alu_op_1, req_tag_0, req_tag_1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op1_0, req_op1_1, req_op2_0, req_op2_1,
           req_alu_op_0, req_alu_op_1, req_tag_0, req_tag_1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU; undefined opcodes yield 0 with err set.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [3:0]      alu_op_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  logic [5:0] shamt;
  assign shamt = op2_i[5:0];

  // Opcode decode; add/sub wrap naturally at XLEN bits.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (alu_op_i)
      ALU_OP_ADD: result_o = op1_i + op2_i;
      ALU_OP_SUB: result_o = op1_i - op2_i;
      ALU_OP_AND: result_o = op1_i & op2_i;
      ALU_OP_OR:  result_o = op1_i | op2_i;
      ALU_OP_XOR: result_o = op1_i ^ op2_i;
      ALU_OP_SLL: result_o = op1_i << shamt;
      ALU_OP_SRL: result_o = op1_i >> shamt;
      ALU_OP_SRA: result_o = $unsigned($signed(op1_i) >>> shamt);
      default:    err_o    = op_undefined(alu_op_i);
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-way round-robin arbiter feeding a one-entry stage register and ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  stage_t           stage_q, stage_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             vld_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  logic stage_free, gnt_vld, gnt_id, accept;

  assign stage_free = !vld_q || bus.rsp_ready;

  // Grant selection: sole requester wins; on contention the one not served last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (bus.req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_id = 1'b0;          end
      2'b10:   begin gnt_vld = 1'b1; gnt_id = 1'b1;          end
      2'b11:   begin gnt_vld = 1'b1; gnt_id = !last_grant_q; end
      default: begin gnt_vld = 1'b0; gnt_id = 1'b0;          end
    endcase
  end

  // Ready is held low throughout reset so nothing is taken while clearing.
  assign accept        = !reset && stage_free && gnt_vld;
  assign bus.req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Mux the winning requester's fields into the next stage record.
  always_comb begin
    stage_d.id = gnt_id;
    if (gnt_id) begin
      stage_d.op1    = bus.req_op1_1;
      stage_d.op2    = bus.req_op2_1;
      stage_d.alu_op = bus.req_alu_op_1;
      tag_d          = bus.req_tag_1;
    end else begin
      stage_d.op1    = bus.req_op1_0;
      stage_d.op2    = bus.req_op2_0;
      stage_d.alu_op = bus.req_alu_op_0;
      tag_d          = bus.req_tag_0;
    end
  end

  // Stage register: load on accept (even while draining, so no bubble), else
  // drop valid once the consumer takes the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q      <= '0;
      tag_q        <= '0;
      vld_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      stage_q      <= stage_d;
      tag_q        <= tag_d;
      vld_q        <= 1'b1;
      last_grant_q <= gnt_id;
    end else if (bus.rsp_ready) begin
      vld_q        <= 1'b0;
    end
  end

  // Per-requester accept counters, free-running with natural wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (accept) begin
      if (gnt_id) cnt1_q <= cnt1_q + 1'b1;
      else        cnt0_q <= cnt0_q + 1'b1;
    end
  end

  // A cleared stage decodes as ADD 0+0, so the result reads 0 out of reset.
  alu_arbiter_alu u_alu (
    .op1_i    (stage_q.op1),
    .op2_i    (stage_q.op2),
    .alu_op_i (stage_q.alu_op),
    .result_o (bus.rsp_result),
    .err_o    (bus.rsp_err)
  );

  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = stage_q.id;
  assign bus.rsp_tag   = tag_q;
  assign grant_cnt_0   = cnt0_q;
  assign grant_cnt_1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: expected results pushed at accept, monitor pops on handoff.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        id;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gc0, gc1;

  alu_arbiter_if #(.TAG_W(4)) bus();

  alu_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .grant_cnt_0 (gc0),
    .grant_cnt_1 (gc1)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  logic        gq[$];
  exp_t        mon_e;
  logic [63:0] exp_res[2];
  logic        exp_err[2];
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor pops on each handoff; tracker then pushes what was just accepted.
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL rsp_unexpected: got result %h with nothing outstanding", bus.rsp_result);
      end else begin
        mon_e = sb.pop_front();
        if (bus.rsp_result !== mon_e.res || bus.rsp_id !== mon_e.id ||
            bus.rsp_tag !== mon_e.tag || bus.rsp_err !== mon_e.err) begin
          n_miss++;
          $display("FAIL rsp: got res=%h id=%0d tag=%0d err=%0d expected res=%h id=%0d tag=%0d err=%0d",
                   bus.rsp_result, bus.rsp_id, bus.rsp_tag, bus.rsp_err,
                   mon_e.res, mon_e.id, mon_e.tag, mon_e.err);
        end
      end
    end
    if (bus.req_valid[0] && bus.req_ready[0]) begin
      sb.push_back('{exp_res[0], 1'b0, bus.req_tag_0, exp_err[0]});
      gq.push_back(1'b0);
    end
    if (bus.req_valid[1] && bus.req_ready[1]) begin
      sb.push_back('{exp_res[1], 1'b1, bus.req_tag_1, exp_err[1]});
      gq.push_back(1'b1);
    end
  end

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [3:0] tg,
                         input logic [63:0] er, input logic ee);
    exp_res[i] = er;
    exp_err[i] = ee;
    if (i == 0) begin
      bus.req_op1_0 = a; bus.req_op2_0 = b; bus.req_alu_op_0 = op; bus.req_tag_0 = tg;
    end else begin
      bus.req_op1_1 = a; bus.req_op2_1 = b; bus.req_alu_op_1 = op; bus.req_tag_1 = tg;
    end
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] op, input logic [3:0] tg,
                      input logic [63:0] er, input logic ee);
    bit ok = 1'b0;
    set_req(i, a, b, op, tg, er, ee);
    bus.req_valid[i] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    bus.req_valid[i] = 1'b0;
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: requester %0d never accepted within 50 cycles", i);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_req(0, '0, '0, ALU_OP_ADD, 4'd0, '0, 1'b0);
    set_req(1, '0, '0, ALU_OP_ADD, 4'd0, '0, 1'b0);

    // Reset state, before any clock edge.
    #3;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_fields", {bus.rsp_id, bus.rsp_tag, bus.rsp_err}, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_cnts", {gc0, gc1}, 0);
    chk("rst_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single request, latency 1, then drain.
    bus.rsp_ready = 1'b1;
    send(0, 64'd5, 64'd3, ALU_OP_SUB, 4'd2, 64'd2, 1'b0);
    chk("lat1_valid", bus.rsp_valid, 1);
    @(posedge clk); #1;
    chk("drain_valid", bus.rsp_valid, 0);

    // Contention alternates 0,1,0,1 starting fresh from reset.
    pulse_reset();
    gq.delete();
    set_req(0, 64'd10, 64'd20, ALU_OP_ADD, 4'd1, 64'd30, 1'b0);
    set_req(1, 64'hF0, 64'hFF, ALU_OP_XOR, 4'd3, 64'h0F, 1'b0);
    bus.req_valid = 2'b11;
    repeat (4) begin @(posedge clk); #1; end
    bus.req_valid = 2'b00;
    chk("alt_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      chk($sformatf("alt_grant_%0d", k), gq[k], k % 2);
    chk("alt_cnt0", gc0, 2);
    chk("alt_cnt1", gc1, 2);
    @(posedge clk); #1;

    // Backpressure hold for 3 cycles, then back-to-back reload.
    bus.rsp_ready = 1'b0;
    send(0, 64'hFF00, 64'h0FF0, ALU_OP_AND, 4'd5, 64'h0F00, 1'b0);
    set_req(1, 64'h1, 64'h2, ALU_OP_OR, 4'd6, 64'h3, 1'b0);
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_result", bus.rsp_result, 64'h0F00);
      chk("hold_idtag", {bus.rsp_err, bus.rsp_id, bus.rsp_tag}, {1'b0, 1'b0, 4'd5});
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    chk("b2b_valid", bus.rsp_valid, 1);
    chk("b2b_result", bus.rsp_result, 64'h3);

    // Operand and opcode corner cases.
    send(1, 64'h8000_0000_0000_0000, 64'h41, ALU_OP_SRA, 4'd7, 64'hC000_0000_0000_0000, 1'b0);
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_OP_ADD, 4'd8, 64'd0, 1'b0);
    send(1, 64'd123, 64'd45, 4'b1010, 4'd9, 64'd0, 1'b1);
    send(0, 64'd0, 64'd1, ALU_OP_SUB, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(1, 64'd1, 64'd63, ALU_OP_SLL, 4'd11, 64'h8000_0000_0000_0000, 1'b0);
    send(0, 64'h8000_0000_0000_0000, 64'd4, ALU_OP_SRL, 4'd12, 64'h0800_0000_0000_0000, 1'b0);
    send(1, 64'h8000_0000_0000_0000, 64'd4, ALU_OP_SRA, 4'd13, 64'hF800_0000_0000_0000, 1'b0);
    send(0, 64'd1, 64'd2, 4'b1111, 4'd14, 64'd0, 1'b1);
    @(posedge clk); #1;

    // Reset mid-flight discards the held result; first contention goes to 0.
    bus.rsp_ready = 1'b0;
    send(0, 64'd7, 64'd1, ALU_OP_SLL, 4'd4, 64'd14, 1'b0);
    chk("pre_rst_valid", bus.rsp_valid, 1);
    #2;
    reset = 1'b1;
    set_req(0, 64'd2, 64'd2, ALU_OP_ADD, 4'd1, 64'd4, 1'b0);
    set_req(1, 64'd9, 64'd4, ALU_OP_SUB, 4'd2, 64'd5, 1'b0);
    bus.req_valid = 2'b11;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_result", bus.rsp_result, 0);
    chk("midrst_ready", bus.req_ready, 0);
    chk("midrst_cnts", {gc0, gc1}, 0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("postrst_grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    // Counter wrap after 65535 + 1 accepts.
    pulse_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 64'd1, 64'd1, ALU_OP_ADD, 4'd9, 64'd2, 1'b0);
    bus.req_valid = 2'b01;
    repeat (65535) begin @(posedge clk); #1; end
    chk("cnt0_max", gc0, 16'hFFFF);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    chk("cnt0_wrap", gc0, 0);
    chk("cnt1_idle", gc1, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
